nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 18 +
 rtl/nibble_serial_adder_ctrl_if.sv | 35 +++
 rtl/nibble_serial_adder_ctrl_rca4.sv | 29 ++
 rtl/nibble_serial_adder_ctrl.sv | 97 +++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl_pkg
// Brief    : Shared state encoding and nibble width for the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_ctrl_pkg;

   localparam int c_NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl_if
// Brief    : Start/busy/done request bus between a driver and the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
);
   localparam int W = c_NIBBLE_W * NIBBLES;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, c_out, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, c_out, ovf
   );

endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_rca4.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl_rca4
// Brief    : Combinational 4-bit ripple-carry adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl_rca4
   import nibble_serial_adder_ctrl_pkg::*;
(
   input  wire logic [c_NIBBLE_W-1:0] i_a,
   input  wire logic [c_NIBBLE_W-1:0] i_b,
   input  wire logic                  i_c,
   output logic      [c_NIBBLE_W-1:0] o_s,
   output logic                       o_c
);

   logic [c_NIBBLE_W:0] w_carry;

   assign w_carry[0] = i_c;

   for (genvar gi = 0; gi < c_NIBBLE_W; gi++) begin : g_bit
      assign o_s[gi]        = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      assign w_carry[gi+1]  = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
   end

   assign o_c = w_carry[c_NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : Wide add/subtract, one nibble per clock through a shared 4-bit cell.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
)(
   input  wire logic                  clk,
   input  wire logic                  rst,
   nibble_serial_adder_ctrl_if.slave  bus
);

   localparam int W     = c_NIBBLE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NIBBLES - 1);

   state_t             r_state;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [IDX_W-1:0]   r_idx;

   logic [IDX_W+1:0]       w_off;
   logic [c_NIBBLE_W-1:0]  w_a_nib;
   logic [c_NIBBLE_W-1:0]  w_b_nib;
   logic [c_NIBBLE_W-1:0]  w_s;
   logic                   w_c;

   assign w_off   = (IDX_W+2)'(r_idx) * (IDX_W+2)'(c_NIBBLE_W);
   assign w_a_nib = r_a[w_off +: c_NIBBLE_W];
   assign w_b_nib = r_b[w_off +: c_NIBBLE_W];

   nibble_serial_adder_ctrl_rca4 u_rca4 (
      .i_a (w_a_nib),
      .i_b (w_b_nib),
      .i_c (r_carry),
      .o_s (w_s),
      .o_c (w_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_state <= ST_RUN;
               end else if (r_state == ST_DONE) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_sum[w_off +: c_NIBBLE_W] <= w_s;
               r_carry <= w_c;
               r_idx   <= r_idx + IDX_W'(1);
               if (r_idx == c_LAST) begin
                  r_cout  <= w_c;
                  r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s[c_NIBBLE_W-1] != r_a[W-1]);
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy  = (r_state == ST_RUN);
   assign bus.done  = (r_state == ST_DONE);
   assign bus.sum   = r_sum;
   assign bus.c_out = r_cout;
   assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Lockstep bench of NIBBLES=2/4/8 instances against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl_if #(.NIBBLES(2)) if2 ();
   nibble_serial_adder_ctrl_if #(.NIBBLES(4)) if4 ();
   nibble_serial_adder_ctrl_if #(.NIBBLES(8)) if8 ();

   nibble_serial_adder_ctrl #(.NIBBLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
   nibble_serial_adder_ctrl #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
   nibble_serial_adder_ctrl #(.NIBBLES(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
   endtask

   function automatic int nib(input int j);
      return 2 << j;
   endfunction

   function automatic logic [31:0] get_sum(input int j);
      case (j)
         0:       return 32'(if2.sum);
         1:       return 32'(if4.sum);
         default: return if8.sum;
      endcase
   endfunction

   function automatic logic [3:0] get_flags(input int j);
      // {busy, done, c_out, ovf}
      case (j)
         0:       return {if2.busy, if2.done, if2.c_out, if2.ovf};
         1:       return {if4.busy, if4.done, if4.c_out, if4.ovf};
         default: return {if8.busy, if8.done, if8.c_out, if8.ovf};
      endcase
   endfunction

   task automatic drive(input bit st, input bit s, input logic [31:0] a, input logic [31:0] b);
      if2.start = st; if2.sub = s; if2.a = a[7:0];  if2.b = b[7:0];
      if4.start = st; if4.sub = s; if4.a = a[15:0]; if4.b = b[15:0];
      if8.start = st; if8.sub = s; if8.a = a;       if8.b = b;
   endtask

   // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
   task automatic model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic c, output logic v);
      longint m    = (longint'(1) << w) - 1;
      longint half = longint'(1) << (w - 1);
      longint ua   = {32'd0, a} & m;
      longint ub   = {32'd0, b} & m;
      longint sa   = (ua >= half) ? ua - (m + 1) : ua;
      longint sb   = (ub >= half) ? ub - (m + 1) : ub;
      longint t, rs;
      if (!s) begin
         t = ua + ub; c = (t > m);   rs = sa + sb;
      end else begin
         t = ua - ub; c = (ua >= ub); rs = sa - sb;
      end
      r = 32'(t & m);
      v = (rs >= half) || (rs < -half);
   endtask

   // mode 0: single op; 1: junk start pulsed during RUN; 2: start held for back-to-back
   task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int mode);
      int          done_k [3];
      int          done2_k[3];
      int          busy_n [3];
      logic        b_after[3];
      logic [31:0] got_s  [3];
      logic        got_c  [3];
      logic        got_v  [3];
      logic [31:0] er;
      logic        ec, ev;
      logic [3:0]  f;
      for (int j = 0; j < 3; j++) begin
         done_k[j] = 0; done2_k[j] = 0; busy_n[j] = 0; b_after[j] = 1'b0;
         got_s[j] = '0; got_c[j] = 1'b0; got_v[j] = 1'b0;
      end
      @(negedge clk);
      drive(1'b1, s, a, b);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (mode == 1 && k == 2)      drive(1'b1, ~s, ~a, ~b);
         else if (mode != 2 || k >= 18) drive(1'b0, s, a, b);
         for (int j = 0; j < 3; j++) begin
            f = get_flags(j);
            if (done_k[j] == 0 && f[3]) busy_n[j]++;
            if (k == nib(j) + 2) b_after[j] = f[3];
            if (f[2]) begin
               if (done_k[j] == 0) begin
                  done_k[j] = k; got_s[j] = get_sum(j); got_c[j] = f[1]; got_v[j] = f[0];
               end else if (done2_k[j] == 0) begin
                  done2_k[j] = k;
               end
            end
         end
      end
      for (int j = 0; j < 3; j++) begin
         model(4 * nib(j), s, a, b, er, ec, ev);
         chk($sformatf("N%0d done_latency", nib(j)), 32'(done_k[j]), 32'(nib(j) + 1));
         chk($sformatf("N%0d busy_cycles", nib(j)),  32'(busy_n[j]), 32'(nib(j)));
         chk($sformatf("N%0d sum", nib(j)),   got_s[j], er);
         chk($sformatf("N%0d c_out", nib(j)), 32'(got_c[j]), 32'(ec));
         chk($sformatf("N%0d ovf", nib(j)),   32'(got_v[j]), 32'(ev));
         chk($sformatf("N%0d sum_hold", nib(j)), get_sum(j), er);
         if (mode == 2) begin
            chk($sformatf("N%0d b2b_done2", nib(j)), 32'(done2_k[j]), 32'(2 * nib(j) + 2));
            chk($sformatf("N%0d b2b_no_idle", nib(j)), 32'(b_after[j]), 32'd1);
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("N%0d %s flags", nib(j), tag), 32'(get_flags(j)), 32'd0);
         chk($sformatf("N%0d %s sum", nib(j), tag), get_sum(j), 32'd0);
      end
   endtask

   task automatic reset_mid_run();
      int n_done = 0;
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_cleared("rst_mid_run");
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         for (int j = 0; j < 3; j++) if (get_flags(j) != 4'b0000) n_done++;
      end
      chk("rst_mid_run no_activity", 32'(n_done), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      run_op(1'b0, 32'h0000_1234, 32'h0000_4321, 0);
      run_op(1'b0, 32'h0000_FFFF, 32'h0000_0001, 0);
      run_op(1'b0, 32'h0000_7FFF, 32'h0000_0001, 0);
      run_op(1'b1, 32'h0000_0005, 32'h0000_0007, 0);
      run_op(1'b1, 32'h0000_8000, 32'h0000_0001, 0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(1'b1, 32'h8000_8080, 32'h7FFF_7F7F, 0);
      run_op(1'b0, 32'h0000_1234, 32'h0000_4321, 1);
      run_op(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 2);

      reset_mid_run();
      run_op(1'b0, 32'h0BAD_CAFE, 32'h1357_9BDF, 0);

      for (int n = 0; n < 40; n++)
         run_op(1'($urandom_range(1, 0)), $urandom, $urandom, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
